// File: rtl/samsung_wl_input_sequencer_pkg.sv
// Shared definitions for the ZID/CSC word-line input sequencer:
// ternary input codes and the sequencer state encoding.
package samsung_wl_input_sequencer_pkg;

    localparam logic [1:0] IN_ZERO = 2'b00;
    localparam logic [1:0] IN_POS  = 2'b01;
    localparam logic [1:0] IN_NEG  = 2'b11;
    localparam logic [1:0] IN_INV  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SENSE  = 3'd3,
        ST_GAP    = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

endpackage

// File: rtl/samsung_wl_input_sequencer_if.sv
// Request and array-side bundle of the word-line input sequencer.
interface samsung_wl_input_sequencer_if #(
    parameter int VECTOR_SIZE = 64,
    parameter int LOG2_VS     = 7
);
    // start is a request taken only in a cycle where busy=0 and abort=0;
    // cnt_start, sense_enable and done are single-cycle pulses with no ready.
    logic                     start;
    logic                     abort;
    logic                     zid_enable;
    logic [LOG2_VS-1:0]       vector_size;
    logic [2*VECTOR_SIZE-1:0] in_vec;
    logic [VECTOR_SIZE-1:0]   wl1_is_vpass;
    logic [VECTOR_SIZE-1:0]   wl2_is_vpass;
    logic [LOG2_VS-1:0]       sel_idx;
    logic                     wl_drive_en;
    logic                     sense_enable;
    logic                     cnt_start;
    logic                     busy;
    logic                     done;
    logic                     enc_err;

    modport master (
        output start, abort, zid_enable, vector_size, in_vec,
        input  wl1_is_vpass, wl2_is_vpass, sel_idx, wl_drive_en,
               sense_enable, cnt_start, busy, done, enc_err
    );

    modport slave (
        input  start, abort, zid_enable, vector_size, in_vec,
        output wl1_is_vpass, wl2_is_vpass, sel_idx, wl_drive_en,
               sense_enable, cnt_start, busy, done, enc_err
    );

endinterface

// File: rtl/samsung_wl_input_sequencer_encoder.sv
// Ternary element to word-line pair encoder: V1/V2 high means that word line
// is driven to Vpass, low means Vread.
module samsung_ternary_wl_encoder
    import samsung_wl_input_sequencer_pkg::*;
(
    input  logic [1:0] code_i,
    output logic       v1_o,
    output logic       v2_o,
    output logic       inv_o
);

    always_comb begin
        v1_o = 1'b0;
        v2_o = 1'b0;
        case (code_i)
            IN_POS:  v2_o = 1'b1;
            IN_NEG:  v1_o = 1'b1;
            default: ;
        endcase
    end

    assign inv_o = (code_i == IN_INV);

endmodule

// File: rtl/samsung_wl_input_sequencer.sv
// Word-line input sequencer: latches an encoded ternary vector and walks the
// synapses, settling each word-line pair and strobing the sense amplifier.
module samsung_wl_input_sequencer
    import samsung_wl_input_sequencer_pkg::*;
#(
    parameter int VECTOR_SIZE   = 64,
    parameter int LOG2_VS       = 7,
    parameter int SETTLE_CYCLES = 2,
    parameter int SETTLE_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    samsung_wl_input_sequencer_if.slave  bus,
    output state_e                       state_o
);

    localparam int                  IDX_W       = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam logic [LOG2_VS-1:0]  VS_MAX      = LOG2_VS'(VECTOR_SIZE);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_e                 state_q;
    logic [LOG2_VS-1:0]     sel_q;
    logic [LOG2_VS-1:0]     s_eff_q;
    logic [SETTLE_W-1:0]    settle_q;
    logic                   zid_q;
    logic [VECTOR_SIZE-1:0] wl1_q;
    logic [VECTOR_SIZE-1:0] wl2_q;
    logic                   enc_err_q;
    logic                   busy_q;
    logic                   cnt_start_q;
    logic                   drive_q;
    logic                   sense_q;
    logic                   done_q;

    logic [LOG2_VS-1:0]     s_req;
    logic [VECTOR_SIZE-1:0] wl1_d;
    logic [VECTOR_SIZE-1:0] wl2_d;
    logic [VECTOR_SIZE-1:0] inv_d;
    logic [LOG2_VS-1:0]     nxt_idx;
    logic                   nxt_skip;
    logic                   seq_last;

    assign s_req = (bus.vector_size > VS_MAX) ? VS_MAX : bus.vector_size;

    // Elements beyond S are forced to Vpass on both lines so they stay transparent.
    for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_enc
        logic v1, v2, inv, in_range;
        samsung_ternary_wl_encoder u_enc (
            .code_i (bus.in_vec[2*i+1:2*i]),
            .v1_o   (v1),
            .v2_o   (v2),
            .inv_o  (inv)
        );
        assign in_range = (LOG2_VS'(i) < s_req);
        assign wl1_d[i] = in_range ? v1 : 1'b1;
        assign wl2_d[i] = in_range ? v2 : 1'b1;
        assign inv_d[i] = in_range & inv;
    end

    // LOAD and GAP share the "enter next synapse" decision; LOAD enters synapse 0.
    assign nxt_idx  = (state_q == ST_GAP) ? sel_q + 1'b1 : '0;
    assign nxt_skip = zid_q & ~wl1_q[nxt_idx[IDX_W-1:0]] & ~wl2_q[nxt_idx[IDX_W-1:0]];
    assign seq_last = (state_q == ST_LOAD) ? (s_eff_q == '0) : (sel_q == s_eff_q - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            s_eff_q     <= '0;
            settle_q    <= '0;
            zid_q       <= 1'b0;
            wl1_q       <= '0;
            wl2_q       <= '0;
            enc_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            cnt_start_q <= 1'b0;
            drive_q     <= 1'b0;
            sense_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_start_q <= 1'b0;
            sense_q     <= 1'b0;
            done_q      <= 1'b0;
            if (bus.abort) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                drive_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state_q     <= ST_LOAD;
                            wl1_q       <= wl1_d;
                            wl2_q       <= wl2_d;
                            enc_err_q   <= |inv_d;
                            s_eff_q     <= s_req;
                            zid_q       <= bus.zid_enable;
                            sel_q       <= '0;
                            busy_q      <= 1'b1;
                            cnt_start_q <= 1'b1;
                        end
                    end
                    ST_LOAD, ST_GAP: begin
                        if (seq_last) begin
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            sel_q <= nxt_idx;
                            if (nxt_skip) begin
                                state_q <= ST_SENSE;
                                sense_q <= 1'b1;
                            end else begin
                                state_q  <= ST_SETTLE;
                                settle_q <= SETTLE_LAST;
                                drive_q  <= 1'b1;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_q == '0) begin
                            state_q <= ST_SENSE;
                            sense_q <= 1'b1;
                        end else begin
                            settle_q <= settle_q - 1'b1;
                        end
                    end
                    ST_SENSE: begin
                        state_q <= ST_GAP;
                        drive_q <= 1'b0;
                    end
                    ST_FIN:  state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.wl1_is_vpass = wl1_q;
    assign bus.wl2_is_vpass = wl2_q;
    assign bus.sel_idx      = sel_q;
    assign bus.wl_drive_en  = drive_q;
    assign bus.sense_enable = sense_q;
    assign bus.cnt_start    = cnt_start_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.enc_err      = enc_err_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_samsung_wl_input_sequencer.sv
// Scoreboard bench for the word-line input sequencer: a cycle-count model of
// each inference fills expected queues that an independent monitor drains.
module tb_samsung_wl_input_sequencer;
  import samsung_wl_input_sequencer_pkg::*;

  localparam int VS     = 64;
  localparam int LW     = 7;
  localparam int SETTLE = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  samsung_wl_input_sequencer_if #(.VECTOR_SIZE(VS), .LOG2_VS(LW)) vif ();
  state_e state_dbg;

  samsung_wl_input_sequencer #(
    .VECTOR_SIZE(VS), .LOG2_VS(LW), .SETTLE_CYCLES(SETTLE), .SETTLE_W(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (vif),
    .state_o (state_dbg)
  );

  int n_checks = 0;
  int n_fail = 0;
  int edge_n = 0;
  int t0 = 0;
  int drive_cnt = 0;
  int last_done_cyc = -1;
  bit done_seen = 1'b0;

  logic [23:0]  sense_q[$];  // {sel_idx, wl_drive_en, cycle}
  logic [128:0] exp_q[$];    // {enc_err, wl1, wl2} checked at cnt_start
  logic [31:0]  done_q[$];   // {done cycle, word-line drive cycles}

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int cyc();
    return edge_n - t0 + 1;
  endfunction

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got a pulse at cycle %0d, expected none", name, cyc());
  endtask

  // reference model: timing from cycles-per-synapse rules
  task automatic model(input int s_req, input logic [127:0] vec, input bit zid);
    int s, c, drv;
    logic [VS-1:0] w1, w2;
    logic enc;
    logic [1:0] code;
    s = (s_req > VS) ? VS : s_req;
    enc = 1'b0;
    for (int i = 0; i < VS; i++) begin
      code = vec[2*i +: 2];
      if (i >= s) begin
        w1[i] = 1'b1; w2[i] = 1'b1;
      end else begin
        w1[i] = (code == 2'b11);
        w2[i] = (code == 2'b01);
        if (code == 2'b10) enc = 1'b1;
      end
    end
    c = 1;
    drv = 0;
    for (int i = 0; i < s; i++) begin
      code = vec[2*i +: 2];
      if (zid && (code == 2'b00 || code == 2'b10)) begin
        c = c + 1;
        sense_q.push_back({7'(i), 1'b0, 16'(c)});
      end else begin
        c = c + SETTLE + 1;
        drv = drv + SETTLE + 1;
        sense_q.push_back({7'(i), 1'b1, 16'(c)});
      end
      c = c + 1;
    end
    exp_q.push_back({enc, w1, w2});
    done_q.push_back({16'(c + 1), 16'(drv)});
  endtask

  // driver tasks
  task automatic issue(input int s, input logic [127:0] vec, input bit zid);
    @(negedge clk);
    model(s, vec, zid);
    vif.vector_size = 7'(s);
    vif.in_vec      = vec;
    vif.zid_enable  = zid;
    vif.start       = 1'b1;
    done_seen       = 1'b0;
    @(posedge clk);
    #1;
    t0 = edge_n;
    vif.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 2000 && !done_seen; k++) @(negedge clk);
    check("done_within_budget", done_seen, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [128:0] p;
    logic [23:0]  e;
    logic [31:0]  d;
    if (rst_n) begin
      if (vif.cnt_start) begin
        drive_cnt = 0;
        if (exp_q.size() == 0) unexpected("cnt_start");
        else begin
          p = exp_q.pop_front();
          check("cnt_start_cycle", 129'(cyc()), 129'(1));
          check("wl1_pattern", 129'(vif.wl1_is_vpass), 129'(p[127:64]));
          check("wl2_pattern", 129'(vif.wl2_is_vpass), 129'(p[63:0]));
          check("enc_err", 129'(vif.enc_err), 129'(p[128]));
          check("busy_at_load", 129'(vif.busy), 129'(1));
        end
      end
      if (vif.wl_drive_en) drive_cnt++;
      if (vif.sense_enable) begin
        if (sense_q.size() == 0) unexpected("sense_enable");
        else begin
          e = sense_q.pop_front();
          check("sense_sel_idx", 129'(vif.sel_idx), 129'(e[23:17]));
          check("sense_wl_drive", 129'(vif.wl_drive_en), 129'(e[16]));
          check("sense_cycle", 129'(16'(cyc())), 129'(e[15:0]));
        end
      end
      if (vif.done) begin
        if (done_q.size() == 0) unexpected("done");
        else begin
          d = done_q.pop_front();
          check("done_cycle", 129'(16'(cyc())), 129'(d[31:16]));
          check("wl_drive_cycles", 129'(16'(drive_cnt)), 129'(d[15:0]));
          check("busy_at_done", 129'(vif.busy), 129'(0));
          check("sense_count", 129'(sense_q.size()), 129'(0));
          last_done_cyc = cyc();
          done_seen = 1'b1;
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, 129'({vif.busy, vif.done, vif.cnt_start, vif.sense_enable,
                      vif.wl_drive_en, vif.enc_err, vif.sel_idx}), 129'(0));
    check({name, "_wl"}, 129'({vif.wl1_is_vpass, vif.wl2_is_vpass}), 129'(0));
  endtask

  logic [127:0] dir_vec;
  logic [127:0] rvec;

  initial begin
    vif.start = 1'b0;
    vif.abort = 1'b0;
    vif.zid_enable = 1'b0;
    vif.vector_size = '0;
    vif.in_vec = '0;
    dir_vec = '0;
    dir_vec[7:0] = 8'b01_00_11_01;  // e0=+1, e1=-1, e2=0, e3=+1

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    check("reset_state", 129'(state_dbg), 129'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // directed ZID run
    issue(4, dir_vec, 1'b1);
    wait_done();
    check("zid_done_cycle", 129'(last_done_cyc), 129'(16));
    check("zid_wl1_low", 129'(vif.wl1_is_vpass[3:0]), 129'(4'b0010));
    check("zid_wl2_low", 129'(vif.wl2_is_vpass[3:0]), 129'(4'b1001));
    check("zid_wl_upper_vpass", 129'({vif.wl1_is_vpass[63:4], vif.wl2_is_vpass[63:4]}), {9'd0, {120{1'b1}}});

    // same vector, zero element settled
    issue(4, dir_vec, 1'b0);
    wait_done();
    check("nozid_done_cycle", 129'(last_done_cyc), 129'(18));

    // empty vector
    issue(0, dir_vec, 1'b1);
    wait_done();
    check("empty_done_cycle", 129'(last_done_cyc), 129'(2));

    // oversize request clamps to VECTOR_SIZE
    rvec = {$urandom, $urandom, $urandom, $urandom};
    issue(100, rvec, 1'($urandom_range(0, 1)));
    wait_done();
    check("clamp_sel_end", 129'(vif.sel_idx), 129'(63));

    // invalid element plus a start while busy
    issue(4, {dir_vec[127:4], 2'b10, dir_vec[1:0]}, 1'b0);
    repeat (5) @(negedge clk);
    vif.start = 1'b1;
    @(negedge clk);
    vif.start = 1'b0;
    wait_done();
    check("invalid_enc_err", 129'(vif.enc_err), 129'(1));
    check("invalid_encoded_zero", 129'({vif.wl1_is_vpass[1], vif.wl2_is_vpass[1]}), 129'(0));

    // abort in SETTLE of synapse 2
    issue(4, dir_vec, 1'b0);
    for (int k = 0; k < 50 && cyc() != 10; k++) @(negedge clk);
    check("abort_point_state", 129'(state_dbg), 129'(ST_SETTLE));
    check("abort_point_sel", 129'(vif.sel_idx), 129'(2));
    check("abort_pending_senses", 129'(sense_q.size()), 129'(2));
    vif.abort = 1'b1;
    @(negedge clk);
    vif.abort = 1'b0;
    sense_q.delete();
    done_q.delete();
    check("abort_idle", 129'({vif.busy, vif.sense_enable, vif.wl_drive_en, vif.done}), 129'(0));
    check("abort_state", 129'(state_dbg), 129'(ST_IDLE));
    check("abort_wl1_hold", 129'(vif.wl1_is_vpass[3:0]), 129'(4'b0010));
    repeat (12) @(negedge clk);

    // abort and start together in IDLE
    vif.start = 1'b1;
    vif.abort = 1'b1;
    @(negedge clk);
    vif.start = 1'b0;
    vif.abort = 1'b0;
    check("abort_beats_start", 129'({vif.busy, state_dbg}), 129'(0));
    repeat (5) @(negedge clk);

    // asynchronous reset during SENSE
    issue(4, dir_vec, 1'b0);
    for (int k = 0; k < 100 && !vif.sense_enable; k++) @(negedge clk);
    check("reset_mid_sense_reached", 129'(vif.sense_enable), 129'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_mid_sense");
    sense_q.delete();
    done_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // random inferences
    for (int n = 0; n < 12; n++) begin
      rvec = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1)) rvec = rvec & {64{2'b01}};  // mostly 0/+1, no invalid codes
      issue($urandom_range(0, 72), rvec, 1'($urandom_range(0, 1)));
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    check("queues_drained", 129'(sense_q.size() + exp_q.size() + done_q.size()), 129'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
